// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control/status bundle between the multi-cycle sequencer and
//                the MIPS-subset datapath. The master side is the sequencer
//                (drives strobes and selects). The slave side is the datapath
//                (returns IR contents, the ALU zero flag and memory ready).
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;
    // Datapath -> sequencer
    logic [31:0] instr;
    logic        zero;
    logic        memReady;

    // Sequencer -> datapath
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        irWrite;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic [2:0]  regDst;
    logic [1:0]  wdSel;
    logic        aluSrc;
    logic [2:0]  extOp;
    logic [2:0]  aluOp;
    logic [2:0]  state;
    logic        retire;

    modport master (
        input  instr, zero, memReady,
        output pcWrite, pcSrc, irWrite, memRead, memWrite, regWrite,
               regDst, wdSel, aluSrc, extOp, aluOp, state, retire
    );

    modport slave (
        output instr, zero, memReady,
        input  pcWrite, pcSrc, irWrite, memRead, memWrite, regWrite,
               regDst, wdSel, aluSrc, extOp, aluOp, state, retire
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
//                MIPS-subset datapath (add, sub, ori, lui, lw, sw, beq, j,
//                jal, jr, jalr). All strobes are combinational from the
//                current state, the decoded IR, zero and memReady.
//                Build option MC_MEM_WAIT_EN: when defined, memReady stretches
//                FETCH and MEM; when undefined, memReady is ignored and every
//                memory access completes in one cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_JALR  = 6'h09;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;

    state_t r_state;
    state_t w_next;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_rtype;
    logic       w_is_add, w_is_sub, w_is_ori, w_is_lui, w_is_lw, w_is_sw;
    logic       w_is_beq, w_is_j, w_is_jal, w_is_jr, w_is_jalr;
    logic       w_goes_exec;
    logic       w_mem_ready;
    logic       w_unused_instr;

    logic       w_pc_write;
    logic [1:0] w_pc_src;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic [2:0] w_reg_dst;
    logic [1:0] w_wd_sel;
    logic       w_alu_src;
    logic [2:0] w_ext_op;
    logic [2:0] w_alu_op;
    logic       w_retire;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = bus.memReady;
`else
    // Every access is treated as completing immediately; the OR keeps the
    // port referenced so the interface stays identical between builds.
    assign w_mem_ready = bus.memReady | 1'b1;
`endif

    // Instruction decode: opcode, plus funct for R-type; the rest is unknown.
    assign w_opcode    = bus.instr[31:26];
    assign w_funct     = bus.instr[5:0];
    assign w_rtype     = (w_opcode == c_OP_RTYPE);
    assign w_is_add    = w_rtype && (w_funct == c_FN_ADD);
    assign w_is_sub    = w_rtype && (w_funct == c_FN_SUB);
    assign w_is_jr     = w_rtype && (w_funct == c_FN_JR);
    assign w_is_jalr   = w_rtype && (w_funct == c_FN_JALR);
    assign w_is_ori    = (w_opcode == c_OP_ORI);
    assign w_is_lui    = (w_opcode == c_OP_LUI);
    assign w_is_lw     = (w_opcode == c_OP_LW);
    assign w_is_sw     = (w_opcode == c_OP_SW);
    assign w_is_beq    = (w_opcode == c_OP_BEQ);
    assign w_is_j      = (w_opcode == c_OP_J);
    assign w_is_jal    = (w_opcode == c_OP_JAL);
    assign w_goes_exec = w_is_add | w_is_sub | w_is_ori | w_is_lui |
                         w_is_lw  | w_is_sw  | w_is_beq;

    // Register fields are consumed by the datapath, not by the sequencer.
    assign w_unused_instr = ^bus.instr[25:6];

    // State register; reset returns the sequencer to FETCH at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state datapath strobes; all quiet while in reset.
    always_comb begin
        w_next      = r_state;
        w_pc_write  = 1'b0;
        w_pc_src    = 2'd0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_reg_dst   = 3'd0;
        w_wd_sel    = 2'd0;
        w_alu_src   = 1'b0;
        w_ext_op    = 3'd0;
        w_alu_op    = 3'd0;
        w_retire    = 1'b0;

        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    w_mem_read = 1'b1;
                    if (w_mem_ready) begin
                        w_ir_write = 1'b1;
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd0;
                        w_next     = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    // Jumps complete here; PC is already PC+4 for the link.
                    if (w_is_j || w_is_jal) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd2;
                    end
                    if (w_is_jal) begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 3'd2;
                        w_wd_sel    = 2'd2;
                    end
                    if (w_is_jr || w_is_jalr) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd3;
                    end
                    if (w_is_jalr) begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 3'd1;
                        w_wd_sel    = 2'd2;
                    end
                    if (w_goes_exec) begin
                        w_next = ST_EXEC;
                    end else begin
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end
                end

                ST_EXEC: begin
                    if (w_is_add || w_is_sub) begin
                        w_alu_src = 1'b0;
                        w_alu_op  = w_is_sub ? 3'd3 : 3'd2;
                    end
                    if (w_is_ori) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = 3'd0;
                        w_alu_op  = 3'd1;
                    end
                    if (w_is_lui) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = 3'd2;
                        w_alu_op  = 3'd2;
                    end
                    if (w_is_lw || w_is_sw) begin
                        w_alu_src = 1'b1;
                        w_ext_op  = 3'd1;
                        w_alu_op  = 3'd2;
                    end
                    if (w_is_beq) begin
                        w_alu_src  = 1'b0;
                        w_alu_op   = 3'd3;
                        w_ext_op   = 3'd1;
                        w_pc_src   = 2'd1;
                        w_pc_write = bus.zero;
                    end

                    if (w_is_lw || w_is_sw) begin
                        w_next = ST_MEM;
                    end else if (w_is_beq) begin
                        w_next   = ST_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = ST_WB;
                    end
                end

                ST_MEM: begin
                    // Request is held every cycle until memory reports ready.
                    w_mem_read  = w_is_lw;
                    w_mem_write = w_is_sw;
                    if (w_mem_ready) begin
                        if (w_is_lw) begin
                            w_next = ST_WB;
                        end else begin
                            w_next   = ST_FETCH;
                            w_retire = 1'b1;
                        end
                    end
                end

                ST_WB: begin
                    w_reg_write = 1'b1;
                    if (w_is_add || w_is_sub) begin
                        w_reg_dst = 3'd1;
                    end
                    if (w_is_lw) begin
                        w_wd_sel = 2'd1;
                    end
                    w_next   = ST_FETCH;
                    w_retire = 1'b1;
                end

                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

    assign bus.pcWrite  = w_pc_write;
    assign bus.pcSrc    = w_pc_src;
    assign bus.irWrite  = w_ir_write;
    assign bus.memRead  = w_mem_read;
    assign bus.memWrite = w_mem_write;
    assign bus.regWrite = w_reg_write;
    assign bus.regDst   = w_reg_dst;
    assign bus.wdSel    = w_wd_sel;
    assign bus.aluSrc   = w_alu_src;
    assign bus.extOp    = w_ext_op;
    assign bus.aluOp    = w_alu_op;
    assign bus.state    = r_state;
    assign bus.retire   = w_retire;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Each
//                instruction is run from FETCH to retire while a per-cycle
//                snapshot of the outputs is logged, then checked against
//                hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

`ifdef MC_MEM_WAIT_EN
    localparam int WAIT_EN = 1;
`else
    localparam int WAIT_EN = 0;
`endif

    typedef struct packed {
        logic [2:0] st;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic [2:0] regDst;
        logic [1:0] wdSel;
        logic       aluSrc;
        logic [2:0] extOp;
        logic [2:0] aluOp;
        logic       retire;
    } snap_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   lat;
    snap_t trace[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic snap_t take();
        snap_t s;
        s.st       = bus.state;
        s.pcWrite  = bus.pcWrite;
        s.pcSrc    = bus.pcSrc;
        s.irWrite  = bus.irWrite;
        s.memRead  = bus.memRead;
        s.memWrite = bus.memWrite;
        s.regWrite = bus.regWrite;
        s.regDst   = bus.regDst;
        s.wdSel    = bus.wdSel;
        s.aluSrc   = bus.aluSrc;
        s.extOp    = bus.extOp;
        s.aluOp    = bus.aluOp;
        s.retire   = bus.retire;
        return s;
    endfunction

    // Runs one instruction starting in FETCH (entered at posedge+1); returns
    // its cycle count or -1 if it never retires. Ends at posedge+1.
    task automatic run_instr(input logic [31:0] ins, input logic z,
                             input int fstall, input int mstall, output int cycles);
        int fs;
        int ms;
        fs = fstall;
        ms = mstall;
        cycles = -1;
        trace.delete();
        bus.instr = ins;
        bus.zero  = z;
        for (int i = 0; i < 40; i++) begin
            bus.memReady = 1'b1;
            if (bus.state == 3'd0 && fs > 0) begin
                bus.memReady = 1'b0;
                fs--;
            end
            if (bus.state == 3'd3 && ms > 0) begin
                bus.memReady = 1'b0;
                ms--;
            end
            #1;
            trace.push_back(take());
            @(posedge clk);
            #1;
            if (trace[i].retire) begin
                cycles = i + 1;
                break;
            end
        end
        bus.memReady = 1'b1;
    endtask

    initial begin
        int exp_st[4];
        int lw_mem;
        n_checks = 0;
        n_fail   = 0;
        reset        = 1'b1;
        bus.instr    = 32'h0;
        bus.zero     = 1'b0;
        bus.memReady = 1'b1;

        // Reset: FETCH with every strobe low even though memReady=1.
        #2;
        check("rst_state",   bus.state,    0);
        check("rst_memRead", bus.memRead,  0);
        check("rst_pcWrite", bus.pcWrite,  0);
        check("rst_irWrite", bus.irWrite,  0);
        check("rst_retire",  bus.retire,   0);
        check("rst_sel",     {bus.pcSrc, bus.regDst, bus.wdSel, bus.aluSrc, bus.extOp, bus.aluOp}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("fetch_strobes", {bus.memRead, bus.irWrite, bus.pcWrite, bus.pcSrc}, 5'b11100);

        // add $3,$1,$2
        run_instr(32'h00221820, 1'b0, 0, 0, lat);
        check("add_lat", lat, 4);
        exp_st = '{0, 1, 2, 4};
        if (lat == 4) begin
            for (int i = 0; i < 4; i++) check($sformatf("add_st%0d", i), trace[i].st, exp_st[i]);
            check("add_exec", {trace[2].aluSrc, trace[2].aluOp, trace[2].regWrite}, {1'b0, 3'd2, 1'b0});
            check("add_wb", {trace[3].regWrite, trace[3].regDst, trace[3].wdSel, trace[3].retire},
                  {1'b1, 3'd1, 2'd0, 1'b1});
        end
        check("add_after", bus.state, 0);

        // sub $3,$1,$2
        run_instr(32'h00221822, 1'b0, 0, 0, lat);
        check("sub_lat", lat, 4);
        if (lat == 4) check("sub_aluOp", trace[2].aluOp, 3);

        // ori $2,$1,5
        run_instr(32'h34220005, 1'b0, 0, 0, lat);
        check("ori_lat", lat, 4);
        if (lat == 4) begin
            check("ori_exec", {trace[2].aluSrc, trace[2].extOp, trace[2].aluOp}, {1'b1, 3'd0, 3'd1});
            check("ori_wb", {trace[3].regWrite, trace[3].regDst, trace[3].wdSel}, {1'b1, 3'd0, 2'd0});
        end

        // lui $2,0x1234
        run_instr(32'h3C021234, 1'b0, 0, 0, lat);
        check("lui_lat", lat, 4);
        if (lat == 4) check("lui_exec", {trace[2].aluSrc, trace[2].extOp, trace[2].aluOp}, {1'b1, 3'd2, 3'd2});

        // lw $2,4($1) with two not-ready cycles in MEM
        lw_mem = (WAIT_EN != 0) ? 3 : 1;
        run_instr(32'h8C220004, 1'b0, 0, 2, lat);
        check("lw_lat", lat, 4 + lw_mem);
        if (lat == 4 + lw_mem) begin
            check("lw_exec", {trace[2].aluSrc, trace[2].extOp, trace[2].aluOp}, {1'b1, 3'd1, 3'd2});
            for (int i = 3; i < 3 + lw_mem; i++)
                check($sformatf("lw_mem%0d", i), {trace[i].st, trace[i].memRead, trace[i].regWrite, trace[i].retire},
                      {3'd3, 1'b1, 1'b0, 1'b0});
            check("lw_wb", {trace[3 + lw_mem].st, trace[3 + lw_mem].regWrite, trace[3 + lw_mem].regDst,
                            trace[3 + lw_mem].wdSel, trace[3 + lw_mem].retire},
                  {3'd4, 1'b1, 3'd0, 2'd1, 1'b1});
        end

        // sw $2,4($1) with memReady low for three MEM cycles
        run_instr(32'hAC220004, 1'b0, 0, 3, lat);
        check("sw_lat", lat, (WAIT_EN != 0) ? 7 : 4);
        if (lat >= 4) check("sw_mem", {trace[3].st, trace[3].memWrite, trace[3].memRead, trace[3].regWrite},
                            {3'd3, 1'b1, 1'b0, 1'b0});

        // add with one not-ready FETCH cycle
        run_instr(32'h00221820, 1'b0, 1, 0, lat);
        check("fstall_lat", lat, 4 + WAIT_EN);
        if (lat >= 4) begin
            check("fstall_c0", {trace[0].st, trace[0].memRead, trace[0].irWrite}, {3'd0, 1'b1, WAIT_EN == 0});
            check("fstall_ir", {trace[WAIT_EN].irWrite, trace[WAIT_EN].pcWrite}, 2'b11);
        end

        // beq $1,$2,3 taken and not taken
        run_instr(32'h10220003, 1'b1, 0, 0, lat);
        check("beqT_lat", lat, 3);
        if (lat == 3) check("beqT_exec", {trace[2].pcWrite, trace[2].pcSrc, trace[2].aluOp, trace[2].extOp,
                                          trace[2].aluSrc, trace[2].retire},
                            {1'b1, 2'd1, 3'd3, 3'd1, 1'b0, 1'b1});
        run_instr(32'h10220003, 1'b0, 0, 0, lat);
        check("beqN_lat", lat, 3);
        if (lat == 3) check("beqN_exec", {trace[2].pcWrite, trace[2].retire}, 2'b01);

        // jal 0x10
        run_instr(32'h0C000010, 1'b0, 0, 0, lat);
        check("jal_lat", lat, 2);
        if (lat == 2) check("jal_dec", {trace[1].pcWrite, trace[1].pcSrc, trace[1].regWrite, trace[1].regDst,
                                        trace[1].wdSel, trace[1].retire},
                            {1'b1, 2'd2, 1'b1, 3'd2, 2'd2, 1'b1});
        check("jal_next", bus.state, 0);

        // j 0x10
        run_instr(32'h08000010, 1'b0, 0, 0, lat);
        check("j_lat", lat, 2);
        if (lat == 2) check("j_dec", {trace[1].pcWrite, trace[1].pcSrc, trace[1].regWrite}, {1'b1, 2'd2, 1'b0});

        // jr $31
        run_instr(32'h03E00008, 1'b0, 0, 0, lat);
        check("jr_lat", lat, 2);
        if (lat == 2) check("jr_dec", {trace[1].pcWrite, trace[1].pcSrc, trace[1].regWrite}, {1'b1, 2'd3, 1'b0});

        // jalr $31,$1
        run_instr(32'h0020F809, 1'b0, 0, 0, lat);
        check("jalr_lat", lat, 2);
        if (lat == 2) check("jalr_dec", {trace[1].pcWrite, trace[1].pcSrc, trace[1].regWrite, trace[1].regDst,
                                         trace[1].wdSel}, {1'b1, 2'd3, 1'b1, 3'd1, 2'd2});

        // unknown opcode
        run_instr(32'hFC000000, 1'b0, 0, 0, lat);
        check("unk_lat", lat, 2);
        if (lat == 2) check("unk_dec", {trace[1].regWrite, trace[1].memWrite, trace[1].pcWrite, trace[1].retire},
                            4'b0001);

        // sw caught in MEM by an asynchronous reset
        bus.instr    = 32'hAC220004;
        bus.memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        bus.memReady = 1'b0;
        #1;
        check("swr_inmem", {bus.state, bus.memWrite}, {3'd3, 1'b1});
        reset = 1'b1;
        #1;
        check("swr_drop", {bus.state, bus.memWrite, bus.regWrite, bus.retire}, {3'd0, 3'b000});
        @(posedge clk);
        #1;
        check("swr_hold", {bus.state, bus.memRead}, {3'd0, 1'b0});
        reset = 1'b0;
        run_instr(32'h00221820, 1'b0, 0, 0, lat);
        check("swr_resume_lat", lat, 4);
        if (lat == 4) check("swr_resume_st", {trace[0].st, trace[1].st, trace[2].st, trace[3].st},
                            {3'd0, 3'd1, 3'd2, 3'd4});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
